// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file arbiter slice.
package regfile_ctrl_pkg;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned REQ_A  = 0;
  localparam int unsigned REQ_B  = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer selects the winner on a tie.
module rr_arb2
  import regfile_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       en,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req[REQ_A] && req[REQ_B]) begin
        gnt[ptr] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto a 4-entry register file and sequences a hardware clear.
module regfile_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a_valid,
  output logic              req_a_ready,
  input  logic              req_a_we,
  input  logic [ADDR_W-1:0] req_a_addr,
  input  logic [N-1:0]      req_a_wdata,
  output logic              rsp_a_valid,
  output logic [N-1:0]      rsp_a_rdata,
  input  logic              req_b_valid,
  output logic              req_b_ready,
  input  logic              req_b_we,
  input  logic [ADDR_W-1:0] req_b_addr,
  input  logic [N-1:0]      req_b_wdata,
  output logic              rsp_b_valid,
  output logic [N-1:0]      rsp_b_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [N-1:0]      rf_din,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [N-1:0]      rf_dout
);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              ptr;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              arb_en;
  logic              rd_a;
  logic              rd_b;

  assign req    = {req_b_valid, req_a_valid};
  // rst_n gates the grant so no handshake or write can slip through while reset is held
  assign arb_en = rst_n && (state == IDLE);

  rr_arb2 u_arb (
    .req (req),
    .en  (arb_en),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign req_a_ready = gnt[REQ_A];
  assign req_b_ready = gnt[REQ_B];
  assign clr_busy    = (state == CLEAR);
  assign rd_a        = gnt[REQ_A] && !req_a_we;
  assign rd_b        = gnt[REQ_B] && !req_b_we;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_din   = '0;
    rf_raddr = '0;
    if (state == CLEAR) begin
      rf_we    = 1'b1;
      rf_waddr = clr_cnt;
    end else if (gnt[REQ_A]) begin
      if (req_a_we) begin
        rf_we    = 1'b1;
        rf_waddr = req_a_addr;
        rf_din   = req_a_wdata;
      end else begin
        rf_raddr = req_a_addr;
      end
    end else if (gnt[REQ_B]) begin
      if (req_b_we) begin
        rf_we    = 1'b1;
        rf_waddr = req_b_addr;
        rf_din   = req_b_wdata;
      end else begin
        rf_raddr = req_b_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      clr_cnt     <= '0;
      ptr         <= 1'(REQ_A);
      rsp_a_valid <= 1'b0;
      rsp_b_valid <= 1'b0;
      rsp_a_rdata <= '0;
      rsp_b_rdata <= '0;
      clr_done    <= 1'b0;
    end else begin
      rsp_a_valid <= rd_a;
      rsp_b_valid <= rd_b;
      if (rd_a) rsp_a_rdata <= rf_dout;
      if (rd_b) rsp_b_rdata <= rf_dout;
      clr_done <= 1'b0;
      if (gnt[REQ_A]) begin
        ptr <= 1'(REQ_B);
      end else if (gnt[REQ_B]) begin
        ptr <= 1'(REQ_A);
      end
      case (state)
        IDLE: begin
          if (clr_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state    <= IDLE;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomised and directed checks of regfile_arbiter against a transaction-level model.
module tb_regfile_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a_valid, req_a_ready, req_a_we;
  logic [1:0] req_a_addr;
  logic [3:0] req_a_wdata;
  logic       rsp_a_valid;
  logic [3:0] rsp_a_rdata;
  logic       req_b_valid, req_b_ready, req_b_we;
  logic [1:0] req_b_addr;
  logic [3:0] req_b_wdata;
  logic       rsp_b_valid;
  logic [3:0] rsp_b_rdata;
  logic       clr_start, clr_busy, clr_done;
  logic       rf_we;
  logic [1:0] rf_waddr, rf_raddr;
  logic [3:0] rf_din, rf_dout;

  always #5 clk = ~clk;

  regfile_arbiter #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_we(req_a_we),
    .req_a_addr(req_a_addr), .req_a_wdata(req_a_wdata),
    .rsp_a_valid(rsp_a_valid), .rsp_a_rdata(rsp_a_rdata),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_we(req_b_we),
    .req_b_addr(req_b_addr), .req_b_wdata(req_b_wdata),
    .rsp_b_valid(rsp_b_valid), .rsp_b_rdata(rsp_b_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_din(rf_din),
    .rf_raddr(rf_raddr), .rf_dout(rf_dout)
  );

  // The register file the arbiter drives
  logic [3:0] rf_mem [4];
  always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_din;
  assign rf_dout = rf_mem[rf_raddr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stimulus per requester (index 0 = A, 1 = B)
  logic       s_v [2];
  logic       s_we[2];
  logic [1:0] s_ad[2];
  logic [3:0] s_wd[2];
  logic       s_clr;

  // Reference model state
  logic [3:0] m_mem [4];
  int         m_ptr;
  bit         m_clearing;
  int         m_clr_idx;
  bit         e_rv[2];
  logic [3:0] e_rd[2];
  bit         e_done;
  int         last_g;

  task automatic apply_inputs();
    req_a_valid = s_v[0]; req_a_we = s_we[0]; req_a_addr = s_ad[0]; req_a_wdata = s_wd[0];
    req_b_valid = s_v[1]; req_b_we = s_we[1]; req_b_addr = s_ad[1]; req_b_wdata = s_wd[1];
    clr_start   = s_clr;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_clearing = 0; m_clr_idx = 0;
    e_rv[0] = 0; e_rv[1] = 0; e_rd[0] = '0; e_rd[1] = '0; e_done = 0;
    last_g = -1;
  endtask

  // One clock cycle: inputs already applied just after the previous rising edge.
  task automatic step();
    int g;
    bit x_we; logic [1:0] x_wa, x_ra; logic [3:0] x_din;
    @(negedge clk);
    g = -1;
    if (!m_clearing) begin
      if (s_v[0] && s_v[1]) g = m_ptr;
      else if (s_v[0]) g = 0;
      else if (s_v[1]) g = 1;
    end
    x_we = 0; x_wa = '0; x_ra = '0; x_din = '0;
    if (m_clearing) begin
      x_we = 1; x_wa = 2'(m_clr_idx);
    end else if (g >= 0) begin
      if (s_we[g]) begin x_we = 1; x_wa = s_ad[g]; x_din = s_wd[g]; end
      else x_ra = s_ad[g];
    end
    check("ready_a", req_a_ready, 32'(g == 0));
    check("ready_b", req_b_ready, 32'(g == 1));
    check("rf_we", rf_we, 32'(x_we));
    check("rf_waddr", rf_waddr, x_wa);
    check("rf_din", rf_din, x_din);
    check("rf_raddr", rf_raddr, x_ra);
    check("clr_busy", clr_busy, 32'(m_clearing));
    check("clr_done", clr_done, 32'(e_done));
    check("rsp_a_valid", rsp_a_valid, 32'(e_rv[0]));
    check("rsp_b_valid", rsp_b_valid, 32'(e_rv[1]));
    check("rsp_a_rdata", rsp_a_rdata, e_rd[0]);
    check("rsp_b_rdata", rsp_b_rdata, e_rd[1]);
    @(posedge clk); #1;
    e_done = 0; e_rv[0] = 0; e_rv[1] = 0;
    if (m_clearing) begin
      m_mem[m_clr_idx] = '0;
      if (m_clr_idx == 3) begin m_clearing = 0; e_done = 1; end
      else m_clr_idx++;
    end else begin
      if (g >= 0) begin
        if (s_we[g]) m_mem[s_ad[g]] = s_wd[g];
        else begin e_rv[g] = 1; e_rd[g] = m_mem[s_ad[g]]; end
        m_ptr = 1 - g;
      end
      if (s_clr) begin m_clearing = 1; m_clr_idx = 0; end
    end
    last_g = g;
  endtask

  task automatic drive(input bit av, input bit awe, input logic [1:0] aad, input logic [3:0] awd,
                       input bit bv, input bit bwe, input logic [1:0] bad, input logic [3:0] bwd,
                       input bit clr);
    s_v[0] = av; s_we[0] = awe; s_ad[0] = aad; s_wd[0] = awd;
    s_v[1] = bv; s_we[1] = bwe; s_ad[1] = bad; s_wd[1] = bwd;
    s_clr = clr;
    apply_inputs();
    step();
  endtask

  task automatic idle_cycle();
    drive(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0, 0);
  endtask

  // Assert reset from just after an edge, check the reset state, then release cleanly.
  task automatic reset_phase();
    rst_n = 1'b0;
    s_v[0] = 1; s_v[1] = 1; s_we[0] = 1; s_we[1] = 0; s_clr = 1;
    apply_inputs();
    #1;
    check("rst_ready_a", req_a_ready, 0);
    check("rst_ready_b", req_b_ready, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_rsp_a_valid", rsp_a_valid, 0);
    check("rst_rsp_b_valid", rsp_b_valid, 0);
    check("rst_rsp_a_rdata", rsp_a_rdata, 0);
    check("rst_rsp_b_rdata", rsp_b_rdata, 0);
    model_reset();
    @(posedge clk); #1;
    check("rst_hold_rf_we", rf_we, 0);
    check("rst_hold_ready_a", req_a_ready, 0);
    s_v[0] = 0; s_v[1] = 0; s_clr = 0;
    apply_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin s_v[i] = 0; s_we[i] = 0; s_ad[i] = '0; s_wd[i] = '0; end
    s_clr = 0;
    model_reset();
    reset_phase();

    // A fills all entries, then reads them back
    drive(1, 1, 2'd0, 4'ha, 0, 0, 2'd0, 4'h0, 0);
    drive(1, 1, 2'd1, 4'hb, 0, 0, 2'd0, 4'h0, 0);
    drive(1, 1, 2'd2, 4'hc, 0, 0, 2'd0, 4'h0, 0);
    drive(1, 1, 2'd3, 4'hd, 0, 0, 2'd0, 4'h0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 2'(i), 4'h0, 0, 0, 2'd0, 4'h0, 0);
    check("rd3_literal", e_rd[0], 4'hd);
    idle_cycle();

    // B write alone leaves the pointer at A, then both contend for four cycles
    drive(0, 0, 2'd0, 4'h0, 1, 1, 2'd1, 4'h7, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 2'd0, 4'h0, 1, 0, 2'd1, 4'h0, 0);
    idle_cycle();

    // Read-after-write across requesters
    drive(1, 1, 2'd2, 4'h5, 0, 0, 2'd0, 4'h0, 0);
    drive(0, 0, 2'd0, 4'h0, 1, 0, 2'd2, 4'h0, 0);
    idle_cycle();
    check("raw_literal", rsp_b_rdata, 4'h5);

    // Clear with A read pending; both hold reads during the clear
    drive(1, 0, 2'd3, 4'h0, 0, 0, 2'd0, 4'h0, 1);
    for (int i = 0; i < 4; i++) drive(1, 0, 2'd3, 4'h0, 1, 0, 2'd1, 4'h0, 1);
    for (int i = 0; i < 4; i++) drive(1, 0, 2'(i), 4'h0, 0, 0, 2'd0, 4'h0, 0);
    idle_cycle();

    // Reset in the second clear cycle: only entry 0 gets zeroed
    drive(1, 1, 2'd0, 4'h7, 0, 0, 2'd0, 4'h0, 0);
    drive(1, 1, 2'd1, 4'h8, 0, 0, 2'd0, 4'h0, 0);
    drive(1, 1, 2'd2, 4'h9, 0, 0, 2'd0, 4'h0, 0);
    drive(1, 1, 2'd3, 4'h6, 0, 0, 2'd0, 4'h0, 0);
    drive(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0, 1);
    idle_cycle();
    reset_phase();
    for (int i = 0; i < 4; i++) drive(0, 0, 2'd0, 4'h0, 1, 0, 2'(i), 4'h0, 0);
    idle_cycle();
    check("midclr_e0", m_mem[0], 4'h0);
    check("midclr_e2", rf_mem[2], 4'h9);
    check("midclr_e3", rf_mem[3], 4'h6);

    // Random traffic honouring hold-until-ready
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < 2; s++) begin
        if (!(s_v[s] && last_g != s)) begin
          s_v[s]  = ($urandom_range(0, 2) != 0);
          s_we[s] = $urandom_range(0, 1) != 0;
          s_ad[s] = 2'($urandom_range(0, 3));
          s_wd[s] = 4'($urandom_range(0, 15));
        end
      end
      s_clr = ($urandom_range(0, 11) == 0);
      apply_inputs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares one 4-entry x N register file (1 write port, 1 combinational read port, synchronous write) between two requesters, A and B.
- Each requester issues read or write operations over a valid/ready handshake; one operation is granted per cycle, with two-way round-robin priority.
- Also sequences a hardware clear that writes zero to all four entries.
- Sits between the requesting datapath blocks and the register file; it is the only block that drives the register file's write-enable and address ports.

Parameters:
N, 4, data width of the register file entries and request/response data.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_a_valid  input  1  requester A has an operation
req_a_ready  output  1  A's operation accepted this cycle
req_a_we  input  1  1 = write, 0 = read
req_a_addr  input  2  register address
req_a_wdata  input  N  write data
rsp_a_valid  output  1  read data valid for A (one-cycle pulse)
rsp_a_rdata  output  N  read data for A
req_b_valid, req_b_ready, req_b_we, req_b_addr, req_b_wdata, rsp_b_valid, rsp_b_rdata: identical to the A ports, for requester B
clr_start  input  1  request a clear of all entries
clr_busy  output  1  clear in progress
clr_done  output  1  one-cycle pulse after the last clear write
rf_we  output  1  register file write enable
rf_waddr  output  2  register file write address
rf_din  output  N  register file write data
rf_raddr  output  2  register file read address
rf_dout  input  N  register file read data (combinational from rf_raddr)

Behaviour:
- Reset (async, rst_n=0) puts the block in this state:
  - state=IDLE, clear counter=0, priority pointer=A.
  - rsp_a_valid=0, rsp_b_valid=0, rsp_*_rdata=0, clr_done=0.
  - clr_busy=0, req_*_ready=0 while reset is asserted.
  - Register file contents are not affected by reset.
- FSM has two states: IDLE and CLEAR.
- IDLE arbitration (combinational grant):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the side the priority pointer selects.
  - req_x_ready=1 only for the granted side; a handshake completes when valid & ready.
- Priority update: after any grant, the pointer moves to the non-granted side. With no grant, the pointer holds.
- Granted write:
  - rf_we=1, rf_waddr=addr, rf_din=wdata in the same cycle; the register file updates at the edge.
  - Writes produce no response.
- Granted read:
  - rf_raddr=addr in the same cycle; rf_dout is registered into rsp_x_rdata at the edge.
  - rsp_x_valid=1 for exactly the next cycle. Latency is 1 cycle.
- Read-after-write to the same address in the next cycle returns the new data.
- When nothing is granted: rf_we=0, rf_raddr=0, rf_waddr=0, rf_din=0.
- rsp_x_rdata holds its last value when rsp_x_valid=0.
- Requesters must hold valid and their fields stable until ready is seen. A change before that is a protocol violation and is not checked.
- Clear sequence:
  - clr_start=1 in IDLE: the same-cycle grant still proceeds; next state=CLEAR, counter=0.
  - In CLEAR: req_a_ready=req_b_ready=0, clr_busy=1, rf_we=1, rf_waddr=counter, rf_din=0. The counter increments each cycle.
  - At counter=3 the next state is IDLE; clr_done=1 for the following cycle (the first IDLE cycle). The clear occupies exactly 4 cycles.
  - clr_start is ignored while in CLEAR.
  - The priority pointer is unchanged by a clear.
- Reset asserted mid-clear: return immediately to the reset state. Entries already written remain zero; the others keep their old contents.

Decomposition:
- Package regfile_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR);
  - constants DEPTH=4 and ADDR_W=2;
  - requester id constants (REQ_A=0, REQ_B=1).
- Sub-module rr_arb2: two-way round-robin arbiter taking two requests, an enable and the pointer register, producing one-hot grants.

Test Plan:
- Reset, then A writes 4'ha/4'hb/4'hc/4'hd to addresses 0..3 on consecutive cycles; then A reads 0..3 -> rsp_a_valid pulses one cycle after each read with rdata a, b, c, d.
- A and B both hold valid reads for 4 cycles starting with pointer=A -> grants alternate A, B, A, B, and each requester gets 2 responses.
- A writes 4'h5 to addr 2 at cycle t; B reads addr 2 at t+1 -> rsp_b_rdata=4'h5 at t+2.
- clr_start with A's read pending -> A granted that cycle, then 4 cycles of rf_we=1 with rf_waddr 0..3 and rf_din=0, and req_*_ready=0 throughout. clr_done pulses once; subsequent reads of 0..3 return 0.
- rst_n pulled low during the 2nd clear cycle -> clr_busy=0 immediately; entry 0 reads 0, entries 2 and 3 keep their prior values.
